// File: rtl/gol_seq_pkg.sv
// Shared constants for the Game-of-Life generation sequencer: FSM state codes
// and default parameter values.
package gol_seq_pkg;

  localparam int ADDR_W_DEF         = 12;
  localparam int GEN_W_DEF          = 16;
  localparam int CLEAR_CYCLES_DEF   = 2;
  localparam int TIMEOUT_CYCLES_DEF = 1000000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_NEXT  = 2'd3;

endpackage

// File: rtl/gol_generation_sequencer_if.sv
// HPS-control and engine-control bundle of the generation sequencer.
// slave = the sequencer itself, master = whoever drives commands/engine status.
interface gol_generation_sequencer_if #(
  parameter int ADDR_W = 12,
  parameter int GEN_W  = 16
);
  logic              io_start;
  logic              io_abort;
  logic [GEN_W-1:0]  io_generations;
  logic [ADDR_W-1:0] io_buffer_a;
  logic [ADDR_W-1:0] io_buffer_b;
  logic              io_busy;
  logic              io_done;
  logic              io_timeout;
  logic [ADDR_W-1:0] io_final_address;
  logic [GEN_W-1:0]  io_gen_count;
  logic              io_engine_reset;
  logic              io_engine_initialize;
  logic [ADDR_W-1:0] io_engine_starting_address;
  logic [ADDR_W-1:0] io_engine_result_address;
  logic              io_engine_completed;

  modport slave (
    input  io_start, io_abort, io_generations, io_buffer_a, io_buffer_b,
           io_engine_completed,
    output io_busy, io_done, io_timeout, io_final_address, io_gen_count,
           io_engine_reset, io_engine_initialize, io_engine_starting_address,
           io_engine_result_address
  );

  modport master (
    output io_start, io_abort, io_generations, io_buffer_a, io_buffer_b,
           io_engine_completed,
    input  io_busy, io_done, io_timeout, io_final_address, io_gen_count,
           io_engine_reset, io_engine_initialize, io_engine_starting_address,
           io_engine_result_address
  );
endinterface

// File: rtl/gol_seq_watchdog.sv
// Per-generation cycle counter; expired is high during the LIMIT-th enabled
// cycle after the last clear. Saturates there until cleared.
module gol_seq_watchdog #(
  parameter int LIMIT = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign expired = enable && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  cnt <= '0;
    else if (clear)             cnt <= '0;
    else if (enable && !expired) cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/gol_generation_sequencer.sv
// Runs the Game-of-Life engine for N generations, ping-ponging between two
// buffers. Optional per-generation watchdog: define GOL_SEQ_WATCHDOG_EN.
module gol_generation_sequencer
  import gol_seq_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int GEN_W          = GEN_W_DEF,
  parameter int CLEAR_CYCLES   = CLEAR_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic                       clock,
  input logic                       reset,
  gol_generation_sequencer_if.slave bus
);
  localparam int CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYCLES - 1);

  if (CLEAR_CYCLES < 1) begin : g_bad_clear
    $error("CLEAR_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]        state, state_nxt;
  logic              start_q, start_edge, kill, wd_expired, enter_clear;
  logic [GEN_W-1:0]  gens, gens_nxt, gen_count, gen_count_nxt;
  logic [ADDR_W-1:0] buf_a, buf_a_nxt, buf_b, buf_b_nxt;
  logic [ADDR_W-1:0] final_addr, final_addr_nxt, src, src_nxt, dst, dst_nxt;
  logic [CNT_W-1:0]  clr_cnt, clr_cnt_nxt;
  logic              done, done_nxt, busy, eng_rst, eng_init;

  assign start_edge = bus.io_start & ~start_q;
  assign kill       = bus.io_abort | wd_expired;

`ifdef GOL_SEQ_WATCHDOG_EN
  logic timeout;

  gol_seq_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (enter_clear),
    .enable  (state == ST_RUN),
    .expired (wd_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                  timeout <= 1'b0;
    else if (state == ST_IDLE && start_edge)    timeout <= 1'b0;
    else if (state != ST_IDLE && wd_expired)    timeout <= 1'b1;
  end

  assign bus.io_timeout = timeout;
`else
  assign wd_expired     = 1'b0;
  assign bus.io_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    gens_nxt       = gens;
    buf_a_nxt      = buf_a;
    buf_b_nxt      = buf_b;
    gen_count_nxt  = gen_count;
    final_addr_nxt = final_addr;
    clr_cnt_nxt    = clr_cnt;
    done_nxt       = done;
    src_nxt        = src;
    dst_nxt        = dst;
    enter_clear    = 1'b0;

    case (state)
      ST_IDLE: if (start_edge) begin
        gens_nxt       = bus.io_generations;
        buf_a_nxt      = bus.io_buffer_a;
        buf_b_nxt      = bus.io_buffer_b;
        gen_count_nxt  = '0;
        final_addr_nxt = bus.io_buffer_a;
        if (bus.io_generations == '0) begin
          done_nxt = 1'b1;
        end else begin
          done_nxt    = 1'b0;
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt == CLR_LAST) state_nxt   = ST_RUN;
        else                     clr_cnt_nxt = clr_cnt + CNT_W'(1);
      end
      ST_RUN: if (bus.io_engine_completed) begin
        state_nxt      = ST_NEXT;
        gen_count_nxt  = gen_count + GEN_W'(1);
        final_addr_nxt = dst;
      end
      default: begin
        // gen_count already holds the just-finished count here
        if (gen_count == gens) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
    endcase

    // abort/watchdog beat any in-flight completion; keep last finished board
    if (state != ST_IDLE && kill) begin
      state_nxt      = ST_IDLE;
      gen_count_nxt  = gen_count;
      final_addr_nxt = final_addr;
      done_nxt       = 1'b0;
    end

    enter_clear = (state_nxt == ST_CLEAR) && (state != ST_CLEAR);
    if (enter_clear) begin
      src_nxt = gen_count_nxt[0] ? buf_b_nxt : buf_a_nxt;
      dst_nxt = gen_count_nxt[0] ? buf_a_nxt : buf_b_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      start_q    <= 1'b1;
      gens       <= '0;
      buf_a      <= '0;
      buf_b      <= '0;
      gen_count  <= '0;
      final_addr <= '0;
      clr_cnt    <= '0;
      done       <= 1'b0;
      src        <= '0;
      dst        <= '0;
      busy       <= 1'b0;
      eng_rst    <= 1'b1;
      eng_init   <= 1'b0;
    end else begin
      state      <= state_nxt;
      start_q    <= bus.io_start;
      gens       <= gens_nxt;
      buf_a      <= buf_a_nxt;
      buf_b      <= buf_b_nxt;
      gen_count  <= gen_count_nxt;
      final_addr <= final_addr_nxt;
      clr_cnt    <= clr_cnt_nxt;
      done       <= done_nxt;
      src        <= src_nxt;
      dst        <= dst_nxt;
      busy       <= (state_nxt != ST_IDLE);
      eng_rst    <= (state_nxt == ST_IDLE) || (state_nxt == ST_CLEAR);
      eng_init   <= (state_nxt == ST_RUN);
    end
  end

  assign bus.io_busy                    = busy;
  assign bus.io_done                    = done;
  assign bus.io_final_address           = final_addr;
  assign bus.io_gen_count               = gen_count;
  assign bus.io_engine_reset            = eng_rst;
  assign bus.io_engine_initialize       = eng_init;
  assign bus.io_engine_starting_address = src;
  assign bus.io_engine_result_address   = dst;
endmodule

// File: tb/tb_gol_generation_sequencer.sv
// Directed bench for gol_generation_sequencer with a 20-cycle engine model.
module tb_gol_generation_sequencer;
  localparam int ADDR_W       = 12;
  localparam int GEN_W        = 16;
  localparam int CLEAR_CYCLES = 2;
`ifdef GOL_SEQ_WATCHDOG_EN
  localparam int TIMEOUT_CYCLES = 100;
`else
  localparam int TIMEOUT_CYCLES = 1000;
`endif
  localparam int ENG_LAT = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #10 clock = ~clock;

  gol_generation_sequencer_if #(.ADDR_W(ADDR_W), .GEN_W(GEN_W)) bus();

  gol_generation_sequencer #(
    .ADDR_W(ADDR_W), .GEN_W(GEN_W),
    .CLEAR_CYCLES(CLEAR_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [GEN_W-1:0]  gens;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] exp_final;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int eng_cnt, rst_busy_cyc, init_cyc, n_gen;
  bit eng_hang, prev_init;
  logic [ADDR_W-1:0] src_log [8];
  logic [ADDR_W-1:0] dst_log [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // one clock: advance, then sample and run the engine model away from the edge
  task automatic step();
    @(posedge clock);
    #1;
    if (bus.io_engine_reset) begin
      eng_cnt = 0;
      bus.io_engine_completed = 1'b0;
    end else if (bus.io_engine_initialize && !eng_hang) begin
      if (eng_cnt >= ENG_LAT - 1) bus.io_engine_completed = 1'b1;
      else eng_cnt++;
    end
    if (bus.io_busy && bus.io_engine_reset) rst_busy_cyc++;
    if (bus.io_engine_initialize) init_cyc++;
    if (bus.io_engine_initialize && !prev_init) begin
      if (n_gen < 8) begin
        src_log[n_gen] = bus.io_engine_starting_address;
        dst_log[n_gen] = bus.io_engine_result_address;
      end
      n_gen++;
    end
    prev_init = bus.io_engine_initialize;
  endtask

  task automatic clear_mon();
    rst_busy_cyc = 0;
    init_cyc     = 0;
    n_gen        = 0;
  endtask

  task automatic launch(input logic [GEN_W-1:0] g, input logic [ADDR_W-1:0] a,
                        input logic [ADDR_W-1:0] b);
    bus.io_generations = g;
    bus.io_buffer_a    = a;
    bus.io_buffer_b    = b;
    clear_mon();
    bus.io_start = 1'b1;
    step();
  endtask

  task automatic wait_done(input string name);
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.io_done) begin ok = 1; break; end
      step();
    end
    if (!ok) chk({name, "_done_budget"}, 32'd0, 32'd1);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{16'd3, 12'h000, 12'h400, 12'h400};
    vecs[1] = '{16'd4, 12'h000, 12'h400, 12'h000};
    vecs[2] = '{16'd1, 12'h123, 12'h456, 12'h456};
    vecs[3] = '{16'd2, 12'h010, 12'h020, 12'h010};
    vecs[4] = '{16'd0, 12'h0ab, 12'h0cd, 12'h0ab};

    bus.io_start = 1'b1;   // held high through reset: must not launch
    bus.io_abort = 1'b0;
    bus.io_generations = '0;
    bus.io_buffer_a = '0;
    bus.io_buffer_b = '0;
    bus.io_engine_completed = 1'b0;
    eng_cnt = 0; eng_hang = 0; prev_init = 0;
    clear_mon();

    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", bus.io_busy, 0);
    chk("rst_done", bus.io_done, 0);
    chk("rst_timeout", bus.io_timeout, 0);
    chk("rst_gen_count", bus.io_gen_count, 0);
    chk("rst_final", bus.io_final_address, 0);
    chk("rst_eng_reset", bus.io_engine_reset, 1);
    chk("rst_eng_init", bus.io_engine_initialize, 0);
    chk("rst_src_dst", {bus.io_engine_starting_address, bus.io_engine_result_address}, 0);
    reset = 1'b0;
    repeat (3) step();
    chk("held_start_no_launch", bus.io_busy, 0);
    bus.io_start = 1'b0;
    step();

    // zero generations: done one cycle after the edge, never busy
    launch(16'd0, 12'h0ab, 12'h0cd);
    chk("zero_done", bus.io_done, 1);
    chk("zero_busy", bus.io_busy, 0);
    chk("zero_final", bus.io_final_address, 12'h0ab);
    bus.io_start = 1'b0;
    repeat (3) step();
    chk("zero_no_init", init_cyc, 0);
    chk("zero_no_busy_reset", rst_busy_cyc, 0);

    // launch timing: CLEAR for 2 cycles, then initialize
    launch(16'd1, 12'h100, 12'h200);
    chk("t1_busy", bus.io_busy, 1);
    chk("t1_done_cleared", bus.io_done, 0);
    chk("t1_rst_init", {bus.io_engine_reset, bus.io_engine_initialize}, 2'b10);
    bus.io_start = 1'b0;
    step();
    chk("t2_rst_init", {bus.io_engine_reset, bus.io_engine_initialize}, 2'b10);
    step();
    chk("t3_rst_init", {bus.io_engine_reset, bus.io_engine_initialize}, 2'b01);
    chk("t3_addrs", {bus.io_engine_starting_address, bus.io_engine_result_address}, 24'h100200);
    // completion timing: init drops and gen_count bumps the cycle after completed
    for (int i = 0; i < 100 && !bus.io_engine_completed; i++) step();
    step();
    chk("tc1_init_low", bus.io_engine_initialize, 0);
    chk("tc1_gen_count", bus.io_gen_count, 1);
    chk("tc1_busy", bus.io_busy, 1);
    wait_done("t");
    chk("t_final", bus.io_final_address, 12'h200);

    for (int v = 0; v < 5; v++) begin
      launch(vecs[v].gens, vecs[v].a, vecs[v].b);
      bus.io_start = 1'b0;
      wait_done($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_gen_count", v), bus.io_gen_count, vecs[v].gens);
      chk($sformatf("vec%0d_final", v), bus.io_final_address, vecs[v].exp_final);
      chk($sformatf("vec%0d_busy", v), bus.io_busy, 0);
      chk($sformatf("vec%0d_reset_cycles", v), rst_busy_cyc, 2 * vecs[v].gens);
      chk($sformatf("vec%0d_n_gen", v), n_gen, vecs[v].gens);
      for (int k = 0; k < int'(vecs[v].gens) && k < 8; k++) begin
        chk($sformatf("vec%0d_src%0d", v, k), src_log[k], (k % 2) ? vecs[v].b : vecs[v].a);
        chk($sformatf("vec%0d_dst%0d", v, k), dst_log[k], (k % 2) ? vecs[v].a : vecs[v].b);
      end
      step();
    end

    // second start edge while busy is ignored
    launch(16'd4, 12'h000, 12'h400);
    bus.io_start = 1'b0;
    repeat (30) step();
    bus.io_start = 1'b1;
    step();
    wait_done("busy_start");
    chk("busy_start_gen_count", bus.io_gen_count, 4);
    chk("busy_start_final", bus.io_final_address, 12'h000);
    chk("busy_start_n_gen", n_gen, 4);
    repeat (3) step();
    chk("busy_start_no_relaunch", bus.io_busy, 0);
    bus.io_start = 1'b0;
    step();

    // abort during generation 2 of 5
    launch(16'd5, 12'h000, 12'h400);
    bus.io_start = 1'b0;
    for (int i = 0; i < 200 && n_gen < 2; i++) step();
    repeat (5) step();
    bus.io_abort = 1'b1;
    step();
    chk("abort_busy", bus.io_busy, 0);
    chk("abort_done", bus.io_done, 0);
    chk("abort_gen_count", bus.io_gen_count, 1);
    chk("abort_final", bus.io_final_address, 12'h400);
    chk("abort_eng", {bus.io_engine_reset, bus.io_engine_initialize}, 2'b10);
    bus.io_abort = 1'b0;
    step();

    // abort and completed in the same cycle: abort wins
    launch(16'd2, 12'h300, 12'h500);
    bus.io_start = 1'b0;
    for (int i = 0; i < 100 && !bus.io_engine_completed; i++) step();
    bus.io_abort = 1'b1;
    step();
    chk("abort_vs_done_gen_count", bus.io_gen_count, 0);
    chk("abort_vs_done_busy", bus.io_busy, 0);
    chk("abort_vs_done_final", bus.io_final_address, 12'h300);
    bus.io_abort = 1'b0;
    step();

    // hung engine
    eng_hang = 1;
    launch(16'd2, 12'h000, 12'h400);
    bus.io_start = 1'b0;
`ifdef GOL_SEQ_WATCHDOG_EN
    for (int i = 0; i < 500; i++) begin
      step();
      if (!bus.io_busy) break;
    end
    chk("wd_timeout", bus.io_timeout, 1);
    chk("wd_busy", bus.io_busy, 0);
    chk("wd_done", bus.io_done, 0);
    chk("wd_run_cycles", init_cyc, 100);
    eng_hang = 0;
    launch(16'd1, 12'h000, 12'h400);
    bus.io_start = 1'b0;
    chk("wd_timeout_cleared", bus.io_timeout, 0);
    wait_done("wd_rerun");
`else
    repeat (300) step();
    chk("hang_still_busy", bus.io_busy, 1);
    chk("hang_timeout_tied", bus.io_timeout, 0);
    eng_hang = 0;
    bus.io_abort = 1'b1;
    step();
    bus.io_abort = 1'b0;
`endif
    step();

    // asynchronous reset mid-RUN with start held high
    launch(16'd3, 12'h040, 12'h080);
    for (int i = 0; i < 20 && !bus.io_engine_initialize; i++) step();
    repeat (3) step();
    reset = 1'b1;
    #2;
    chk("areset_busy", bus.io_busy, 0);
    chk("areset_eng", {bus.io_engine_reset, bus.io_engine_initialize}, 2'b10);
    chk("areset_counts", {bus.io_gen_count, bus.io_final_address}, 0);
    chk("areset_addrs", {bus.io_engine_starting_address, bus.io_engine_result_address}, 0);
    chk("areset_done", bus.io_done, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (4) step();
    chk("areset_no_relaunch", bus.io_busy, 0);
    bus.io_start = 1'b0;
    step();
    bus.io_start = 1'b1;
    step();
    chk("areset_relaunch", bus.io_busy, 1);
    bus.io_start = 1'b0;
    bus.io_abort = 1'b1;
    step();
    bus.io_abort = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
